uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  UART RX frame controller. Sits upstream of the stop/parity/start checkers and the deserializer.
//  Tracks the frame from start bit to stop bit using an oversampling edge/bit counter.
//  Drives the sampler and checker enables, the DONE strobe and the enable/clearFlag line.
//  Raises data_valid for one cycle when a frame completes error-free.
// PARAMETERS
//  PRESCALE_W  6  width of Prescale and edge_cnt; supported oversampling ratios are 8, 16 and 32
//  DATA_W      8  data bits per frame, LSB first
// PORTS
//  CLK          in   1           clock
//  RST          in   1           asynchronous reset, active-low
//  RX_IN        in   1           serial line (idle high); synchronised upstream
//  Prescale     in   PRESCALE_W  oversampling ratio; static while state != IDLE
//  PAR_EN       in   1           1 = frame contains a parity bit
//  strt_glitch  in   1           from start checker; 1 = sampled start bit was 1
//  par_err      in   1           from parity checker
//  stp_err      in   1           from stop checker
//  edge_cnt     out  PRESCALE_W  oversample index within the current bit, 0..Prescale-1
//  bit_cnt      out  BC_W        bit index in the frame; BC_W = $clog2(DATA_W+3)
//  dat_samp_en  out  1           sampler enable
//  enable       out  1           counter enable; also the clearFlag input of the checkers (low clears)
//  samp_done    out  1           DONE strobe: sampled_bit is valid this cycle
//  strt_chk_en  out  1           start-bit check window
//  deser_en     out  1           deserializer shift window
//  par_chk_en   out  1           parity check window
//  stp_chk_en   out  1           stop check window
//  data_valid   out  1           one-cycle pulse when the frame is good
// BEHAVIOUR
//  Reset: state = IDLE, edge_cnt = 0, bit_cnt = 0, all outputs 0. Asserting RST mid-frame aborts to IDLE.
//  Counter:
//   - enable = 0: edge_cnt and bit_cnt are held at 0.
//   - enable = 1: edge_cnt increments each cycle. At Prescale-1 it wraps to 0 and bit_cnt increments.
//  last_edge = enable && edge_cnt == Prescale-1.
//  samp_done = enable && edge_cnt == (Prescale>>1)+2. It is 1 cycle per bit, after the 3-sample majority vote.
//  Bit numbering: start = 0, data = 1..DATA_W, parity = DATA_W+1, stop = DATA_W+1+PAR_EN.
//  States (registered, Moore outputs):
//   IDLE    enable=0. RX_IN==0 -> START.
//   START   strt_chk_en=1. On last_edge: strt_glitch ? IDLE : DATA.
//   DATA    deser_en=1. On last_edge && bit_cnt==DATA_W: PAR_EN ? PARITY : STOP.
//   PARITY  par_chk_en=1. On last_edge -> STOP.
//   STOP    stp_chk_en=1. On last_edge -> CHECK.
//   CHECK   one cycle, enable=0. data_valid = !par_err && !stp_err.
//           Next state: RX_IN==0 ? START : IDLE (back-to-back frames).
//  enable = 1 in START/DATA/PARITY/STOP, 0 in IDLE/CHECK.
//   - Checkers clear their flags at the CHECK->next edge.
//   - Error flags are therefore still valid during CHECK.
//  dat_samp_en = enable.
//  par_err is ignored when PAR_EN=0 (treated as 0).
//  Simultaneous events:
//   - strt_glitch is sampled only on START's last_edge. The glitch abort takes priority; no data_valid.
//   - A stop error suppresses data_valid. No retry; the FSM returns to IDLE or START.
//  Width rules: edge_cnt compare uses the full PRESCALE_W bits; bit_cnt never exceeds DATA_W+2.
//  A Prescale change while not IDLE is unsupported (no required behaviour).
// STRUCTURE
//  Shared package uart_rx_pkg:
//   - state encoding localparams: IDLE, START, DATA, PARITY, STOP, CHECK (3-bit binary)
//   - BC_W function
//  Sub-module edge_bit_counter (CLK, RST, enable, Prescale -> edge_cnt, bit_cnt, last_edge).
//  Top: state register, next-state logic, output decode.
// TESTING
//  1 Prescale=8, PAR_EN=0, frame 0x55 with stop=1:
//    -> data_valid pulse exactly 10*8+1 cycles after the RX_IN falling edge; stp_chk_en high for 8 cycles.
//  2 Prescale=16, PAR_EN=1, 0xA3 with correct even parity:
//    -> PARITY visited for 16 cycles; data_valid=1; bit_cnt reaches 10.
//  3 Stop bit driven 0 (stp_err=1 at samp_done):
//    -> no data_valid; CHECK lasts 1 cycle; enable=0 in CHECK; next state IDLE.
//  4 RX_IN low for only 2 cycles at Prescale=8 (strt_glitch=1):
//    -> return to IDLE after 8 cycles; deser_en never asserted.
//  5 Two frames back-to-back (second start bit begins in the CHECK cycle):
//    -> CHECK -> START directly; two data_valid pulses.
//  6 RST low in DATA at bit_cnt=4:
//    -> all outputs 0 immediately; the next start bit produces a full, normal frame.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// UART RX frame controller: shared state encoding and width helper.
// Imported by the FSM top and by the bench.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_e;

  function automatic int bc_w(input int data_w);
    return $clog2(data_w + 3);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and frame bit counter.
// Both counters stay cleared while enable is low.
module edge_bit_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BC_W       = 4,
  parameter int BIT_MAX    = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BC_W-1:0]       bit_cnt,
  output logic                  last_edge
);

  localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);
  localparam logic [BC_W-1:0]       B_ONE = BC_W'(1);
  localparam logic [BC_W-1:0]       B_MAX = BC_W'(BIT_MAX);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BC_W-1:0]       bit_q, bit_d;

  assign last_edge = enable && (edge_q == Prescale - E_ONE);

  always_comb begin
    edge_d = edge_q + E_ONE;
    bit_d  = bit_q;
    if (!enable) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (last_edge) begin
      edge_d = '0;
      // saturate so the stop-bit wrap never exceeds the frame length
      if (bit_q != B_MAX) bit_d = bit_q + B_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: tracks start..stop bits and drives
// the sampler/checker enables and the data_valid strobe.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter  int PRESCALE_W = 6,
  parameter  int DATA_W     = 8,
  localparam int BC_W       = bc_w(DATA_W)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BC_W-1:0]       bit_cnt,
  output logic                  dat_samp_en,
  output logic                  enable,
  output logic                  samp_done,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);

  localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_W);

  state_e                state_q, state_d;
  logic                  last_edge;
  logic [PRESCALE_W-1:0] samp_pt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BC_W       (BC_W),
    .BIT_MAX    (DATA_W + 2)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .Prescale  (Prescale),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge)
  );

  // centre sample plus two cycles for the 3-sample majority vote
  assign samp_pt     = (Prescale >> 1) + PRESCALE_W'(2);
  assign samp_done   = enable && (edge_cnt == samp_pt);
  assign dat_samp_en = enable;

  always_comb begin
    state_d     = state_q;
    enable      = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!RX_IN) state_d = START;
      end
      START: begin
        enable      = 1'b1;
        strt_chk_en = 1'b1;
        if (last_edge) state_d = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        enable   = 1'b1;
        deser_en = 1'b1;
        if (last_edge && bit_cnt == LAST_DATA)
          state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        enable     = 1'b1;
        par_chk_en = 1'b1;
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        enable     = 1'b1;
        stp_chk_en = 1'b1;
        if (last_edge) state_d = CHECK;
      end
      CHECK: begin
        data_valid = !stp_err && !(PAR_EN && par_err);
        state_d    = RX_IN ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomised scoreboard bench for uart_rx_fsm with simple
// behavioural start/parity/stop checkers and a deserializer.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int PW  = 6;
  localparam int DW  = 8;
  localparam int BCW = bc_w(DW);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BCW-1:0] bit_cnt;
  logic dat_samp_en, enable, samp_done, strt_chk_en;
  logic deser_en, par_chk_en, stp_chk_en, data_valid;

  uart_rx_fsm #(.PRESCALE_W(PW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .Prescale(Prescale), .PAR_EN(PAR_EN),
    .strt_glitch(strt_glitch), .par_err(par_err),
    .stp_err(stp_err), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .enable(enable), .samp_done(samp_done),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, edge_cnt, bit_cnt, dat_samp_en, enable,
            samp_done, strt_chk_en, deser_en, par_chk_en,
            stp_chk_en, data_valid};
  endfunction

  // upstream checkers and deserializer; flags clear while enable=0
  logic [DW-1:0] sh_q = '0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      sh_q        <= '0;
    end else if (!enable) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      sh_q        <= '0;
    end else if (samp_done) begin
      if (strt_chk_en) strt_glitch <= RX_IN;
      if (deser_en)    sh_q <= {RX_IN, sh_q[DW-1:1]};
      if (par_chk_en)  par_err <= ^{sh_q, RX_IN};
      if (stp_chk_en) begin
        stp_err <= !RX_IN;
        if (!PAR_EN) par_err <= 1'($urandom);
      end
    end
  end

  typedef struct {
    bit          glitch;
    bit          good;
    bit          b2b;
    int          nbits;
    int          p;
    int          pe;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];

  // expected outcome of a frame from its line content alone
  function automatic exp_t model(input logic [7:0] d, input bit pe,
                                 input int p, input bit glitch,
                                 input bit bad_stop, input bit bad_par,
                                 input bit b2b);
    exp_t e;
    e.glitch = glitch;
    e.p      = p;
    e.pe     = int'(pe);
    e.data   = d;
    e.b2b    = b2b && !glitch;
    e.nbits  = glitch ? 1 : DW + 2 + int'(pe);
    e.good   = !glitch && !bad_stop && !(pe && bad_par);
    return e;
  endfunction

  task automatic do_abort(input int exp_bit);
    chk("abort_bitcnt", 32'(bit_cnt), 32'(exp_bit));
    #1;
    RST = 1'b0;
    #1;
    chk("abort_outs_zero", outs(), 32'd0);
    q.delete();
    RX_IN = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe,
                            input int p, input bit glitch,
                            input bit bad_stop, input bit bad_par,
                            input bit b2b, input int gap,
                            input int abort_bit);
    logic bits [0:DW+2];
    int   n;
    q.push_back(model(d, pe, p, glitch, bad_stop, bad_par, b2b));
    if (glitch) begin
      RX_IN = 1'b0;
      repeat (2) tick();
      RX_IN = 1'b1;
      repeat (gap) tick();
      return;
    end
    n = DW + 2 + int'(pe);
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    if (pe) bits[DW+1] = (^d) ^ bad_par;
    bits[n-1] = !bad_stop;
    for (int i = 0; i < n; i++) begin
      RX_IN = bits[i];
      if (i == abort_bit) begin
        repeat (3) tick();
        do_abort(abort_bit);
        return;
      end
      repeat (p) tick();
    end
    RX_IN = 1'b1;
    repeat (gap) tick();
  endtask

  // monitor: per-cycle bookkeeping, pops on every end of enable
  int len = 0, dc = 0, pc = 0, sc = 0, sd = 0;
  int stray = 0, errc = 0, lowrun = 0;
  bit prev_en = 0, last_b2b = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_en = 0; last_b2b = 0;
        len = 0; dc = 0; pc = 0; sc = 0; sd = 0; lowrun = 0;
      end else if (enable) begin
        if (!prev_en) begin
          if (last_b2b) chk("b2b_check_cycles", 32'(lowrun), 32'd1);
          last_b2b = 0;
        end
        if (int'(edge_cnt) != len % int'(Prescale)) errc++;
        if (int'(bit_cnt) != len / int'(Prescale)) errc++;
        if (dat_samp_en !== 1'b1) errc++;
        if (deser_en) dc++;
        if (par_chk_en) pc++;
        if (stp_chk_en) sc++;
        if (samp_done) sd++;
        if (data_valid) stray++;
        len++;
        prev_en = 1;
      end else begin
        if (edge_cnt != 0 || int'(bit_cnt) > DW + 2) errc++;
        if (dat_samp_en || samp_done || strt_chk_en || deser_en ||
            par_chk_en || stp_chk_en) errc++;
        if (prev_en) begin
          lowrun = 0;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_end: got unexpected frame want none");
          end else begin
            e = q.pop_front();
            chk("enable_cycles", 32'(len), 32'(e.nbits * e.p));
            chk("data_valid", 32'(data_valid), 32'(e.good));
            chk("deser_cycles", 32'(dc), e.glitch ? 0 : 32'(DW * e.p));
            chk("par_cycles", 32'(pc),
                (!e.glitch && e.pe != 0) ? 32'(e.p) : 32'd0);
            chk("stp_cycles", 32'(sc), e.glitch ? 0 : 32'(e.p));
            chk("samp_done_count", 32'(sd), 32'(e.nbits));
            chk("counter_errs", 32'(errc), 32'd0);
            chk("stray_data_valid", 32'(stray), 32'd0);
            if (e.good) chk("deser_data", 32'(sh_q), 32'(e.data));
            last_b2b = e.b2b;
          end
          len = 0; dc = 0; pc = 0; sc = 0; sd = 0;
          errc = 0; stray = 0;
        end else if (data_valid) stray++;
        lowrun++;
        prev_en = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic measure(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (data_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int p, gap;
    bit pe, gl, bs, bp, b2b, locked;
    int r;
    logic [7:0] d;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", outs(), 32'd0);
    RST = 1'b1;
    repeat (3) tick();
    chk("idle_outs", outs(), 32'd0);

    Prescale = 6'd8; PAR_EN = 1'b0;
    fork
      send_frame(8'h55, 0, 8, 0, 0, 0, 0, 6, -1);
      measure(lat);
    join
    chk("latency_81", 32'(lat), 32'd81);

    Prescale = 6'd16; PAR_EN = 1'b1;
    send_frame(8'hA3, 1, 16, 0, 0, 0, 0, 6, -1);

    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'h3C, 0, 8, 0, 1, 0, 0, 6, -1);
    send_frame(8'h00, 0, 8, 1, 0, 0, 0, 12, -1);
    send_frame(8'h96, 0, 8, 0, 0, 0, 1, 1, -1);
    send_frame(8'h69, 0, 8, 0, 0, 0, 0, 6, -1);
    send_frame(8'hF0, 0, 8, 0, 0, 0, 0, 6, 4);
    send_frame(8'h0F, 0, 8, 0, 0, 0, 0, 6, -1);

    locked = 0; p = 8; pe = 0;
    for (int i = 0; i < 40; i++) begin
      if (!locked) begin
        r  = $urandom_range(0, 2);
        p  = (r == 0) ? 8 : (r == 1) ? 16 : 32;
        pe = 1'($urandom);
        Prescale = PW'(p);
        PAR_EN   = pe;
      end
      d   = 8'($urandom);
      r   = $urandom_range(0, 99);
      gl  = !locked && r < 10;
      bs  = r >= 10 && r < 25;
      bp  = r >= 25 && r < 40;
      b2b = !gl && i < 39 && $urandom_range(0, 2) == 0;
      gap = gl ? p + 4 + $urandom_range(0, 3)
               : (b2b ? 1 : $urandom_range(3, 10));
      send_frame(d, pe, p, gl, bs, bp, b2b, gap, -1);
      locked = b2b;
    end

    for (int k = 0; k < 3000 && q.size() != 0; k++) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    repeat (4) tick();
    chk("tail_idle_errs", 32'(errc + stray), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
